// File: rtl/ram_stream_reader_pkg.sv
// Shared state encoding and default widths for the RAM16K stream reader.
package ram_stream_reader_pkg;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_stream_reader_rd_addr_counter.sv
// Loadable wrap-around word address plus remaining-length down-counter.
// Load and step take effect on the next edge; o_last flags one word left.
module rd_addr_counter #(
   parameter int ADDR_W = 14,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [LEN_W-1:0]  i_len,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_rem;

   // Address wraps naturally at 2^ADDR_W.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr <= '0;
         r_rem  <= '0;
      end else if (i_load) begin
         r_addr <= i_base;
         r_rem  <= i_len;
      end else if (i_step) begin
         r_addr <= r_addr + ADDR_W'(1);
         r_rem  <= r_rem - LEN_W'(1);
      end
   end

   assign o_addr = r_addr;
   assign o_last = (r_rem == LEN_W'(1));

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a RAM16K address range and streams words out on valid/ready, one word per 2 cycles peak.
// Optional running checksum output enabled by RAM_RD_CHECKSUM_EN.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [LEN_W-1:0]  i_len,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [DATA_W-1:0] o_mem_in,
   output logic              o_mem_load,
   input  logic [DATA_W-1:0] i_mem_out,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last
`ifdef RAM_RD_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] o_checksum
`endif
);

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_data;
   logic              w_accept;
   logic              w_load;
   logic              w_step;
   logic              w_last;
   logic [ADDR_W-1:0] w_addr;

   assign w_accept = (r_state == S_IDLE) && i_start;
   assign w_load   = w_accept && (i_len != '0);
   assign w_step   = (r_state == S_SEND) && i_out_ready;

   rd_addr_counter #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_load),
      .i_base  (i_base),
      .i_len   (i_len),
      .i_step  (w_step),
      .o_addr  (w_addr),
      .o_last  (w_last)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = (i_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: w_next = S_SEND;
         S_SEND: begin
            if (i_out_ready) begin
               w_next = w_last ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // RAM output is combinational on the address, so it is sampled at the end of FETCH.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_data <= '0;
      end else if (r_state == S_FETCH) begin
         r_data <= i_mem_out;
      end
   end

`ifdef RAM_RD_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= '0;
      end else if (w_step) begin
         r_checksum <= r_checksum + r_data;
      end
   end

   assign o_checksum = r_checksum;
`endif

   assign o_busy        = (r_state == S_FETCH) || (r_state == S_SEND);
   assign o_done        = (r_state == S_DONE);
   assign o_mem_address = w_addr;
   assign o_mem_in      = '0;
   assign o_mem_load    = 1'b0;
   assign o_out_valid   = (r_state == S_SEND);
   assign o_out_data    = r_data;
   assign o_out_last    = (r_state == S_SEND) && w_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural RAM16K model.
module tb_ram_stream_reader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [13:0] base;
   logic [14:0] len;
   logic        busy;
   logic        done;
   logic [13:0] mem_address;
   logic [15:0] mem_in;
   logic        mem_load;
   logic [15:0] mem_out;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
`ifdef RAM_RD_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   logic [15:0] ram [0:16383];
   int          checks;
   int          failures;
   int          done_cnt;

   assign mem_out = ram[mem_address];

   ram_stream_reader dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_base        (base),
      .i_len         (len),
      .o_busy        (busy),
      .o_done        (done),
      .o_mem_address (mem_address),
      .o_mem_in      (mem_in),
      .o_mem_load    (mem_load),
      .i_mem_out     (mem_out),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_data    (out_data),
      .o_out_last    (out_last)
`ifdef RAM_RD_CHECKSUM_EN
      ,
      .o_checksum    (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      checks++;
      if ({busy, done, out_valid, out_last} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000", {busy, done, out_valid, out_last});
      end
      checks++;
      if (out_data !== 16'h0000) begin
         failures++;
         $display("FAIL reset_out_data got=%h want=0000", out_data);
      end
      checks++;
      if (mem_address !== 14'd0 || mem_load !== 1'b0 || mem_in !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mem got addr=%0d load=%b in=%h want 0/0/0", mem_address, mem_load, mem_in);
      end
`ifdef RAM_RD_CHECKSUM_EN
      checks++;
      if (checksum !== 16'h0000) begin
         failures++;
         $display("FAIL reset_checksum got=%h want=0000", checksum);
      end
`endif
      reset = 1'b0;
      tick;
   endtask

   task automatic test_stream;
      logic [15:0] exp [4];
      int d0;
      exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      d0 = done_cnt;
      out_ready = 1'b1;
      base = 14'd0;
      len = 15'd4;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || mem_address !== 14'd0) begin
         failures++;
         $display("FAIL stream_fetch0 got busy=%b valid=%b addr=%0d want 1/0/0", busy, out_valid, mem_address);
      end
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
            failures++;
            $display("FAIL stream_word%0d got valid=%b data=%h last=%b want 1/%h/%b", i, out_valid, out_data, out_last, exp[i], (i == 3));
         end
         tick;
         if (i < 3) begin
            checks++;
            if (out_valid !== 1'b0 || mem_address !== 14'(i + 1) || done !== 1'b0) begin
               failures++;
               $display("FAIL stream_gap%0d got valid=%b addr=%0d done=%b want 0/%0d/0", i, out_valid, mem_address, done, i + 1);
            end
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_done got done=%b busy=%b valid=%b want 1/0/0", done, busy, out_valid);
      end
      tick;
      checks++;
      if (done !== 1'b0 || done_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL stream_done_once got done=%b pulses=%0d want 0/1", done, done_cnt - d0);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] exp [4];
      exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      out_ready = 1'b0;
      base = 14'd0;
      len = 15'd4;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
         failures++;
         $display("FAIL bp_first got valid=%b data=%h want 1/1111", out_valid, out_data);
      end
      for (int c = 0; c < 5; c++) begin
         tick;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d got valid=%b data=%h last=%b want 1/1111/0", c, out_valid, out_data, out_last);
         end
      end
      out_ready = 1'b1;
      tick;
      for (int i = 1; i < 4; i++) begin
         tick;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
            failures++;
            $display("FAIL bp_word%0d got valid=%b data=%h last=%b want 1/%h/%b", i, out_valid, out_data, out_last, exp[i], (i == 3));
         end
         tick;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL bp_done got=%b want=1", done);
      end
      tick;
   endtask

   task automatic test_wrap;
      int load_hits;
      load_hits = 0;
      ram[16383] = 16'hBEEF;
      ram[0] = 16'hCAFE;
      out_ready = 1'b1;
      base = 14'd16383;
      len = 15'd2;
      start = 1'b1;
      tick;
      start = 1'b0;
      if (mem_load !== 1'b0) load_hits++;
      checks++;
      if (mem_address !== 14'd16383) begin
         failures++;
         $display("FAIL wrap_addr0 got=%0d want=16383", mem_address);
      end
      tick;
      if (mem_load !== 1'b0) load_hits++;
      checks++;
      if (out_data !== 16'hBEEF || out_last !== 1'b0) begin
         failures++;
         $display("FAIL wrap_word0 got data=%h last=%b want beef/0", out_data, out_last);
      end
      tick;
      if (mem_load !== 1'b0) load_hits++;
      checks++;
      if (mem_address !== 14'd0) begin
         failures++;
         $display("FAIL wrap_addr1 got=%0d want=0", mem_address);
      end
      tick;
      if (mem_load !== 1'b0) load_hits++;
      checks++;
      if (out_data !== 16'hCAFE || out_last !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL wrap_word1 got data=%h last=%b valid=%b want cafe/1/1", out_data, out_last, out_valid);
      end
      tick;
      if (mem_load !== 1'b0) load_hits++;
      checks++;
      if (done !== 1'b1 || load_hits !== 0) begin
         failures++;
         $display("FAIL wrap_done got done=%b load_cycles=%0d want 1/0", done, load_hits);
      end
      tick;
      ram[0] = 16'h1111;
   endtask

   task automatic test_len_zero;
      int d0;
      d0 = done_cnt;
      out_ready = 1'b1;
      base = 14'd5;
      len = 15'd0;
      start = 1'b1;
      tick;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL len0_done got done=%b busy=%b valid=%b want 1/0/0", done, busy, out_valid);
      end
      // Start held into the DONE cycle with a nonzero length must not launch a transfer.
      len = 15'd1;
      tick;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL len0_after got done=%b busy=%b valid=%b want 0/0/0", done, busy, out_valid);
      end
      tick;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL len0_idle got busy=%b valid=%b pulses=%0d want 0/0/1", busy, out_valid, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      out_ready = 1'b1;
      base = 14'd0;
      len = 15'd4;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (5) tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h3333) begin
         failures++;
         $display("FAIL rmid_pre got valid=%b data=%h want 1/3333", out_valid, out_data);
      end
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || mem_address !== 14'd0) begin
         failures++;
         $display("FAIL rmid_async got valid=%b busy=%b addr=%0d want 0/0/0", out_valid, busy, mem_address);
      end
      tick;
      tick;
      reset = 1'b0;
      tick;
      checks++;
      if (done !== 1'b0 || done_cnt !== d0) begin
         failures++;
         $display("FAIL rmid_nodone got done=%b pulses=%0d want 0/0", done, done_cnt - d0);
      end
      base = 14'd2;
      len = 15'd2;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (mem_address !== 14'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rmid_restart got addr=%0d busy=%b want 2/1", mem_address, busy);
      end
      tick;
      checks++;
      if (out_data !== 16'h3333 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL rmid_word0 got data=%h last=%b want 3333/0", out_data, out_last);
      end
      base = 14'd0;
      len = 15'd1;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (mem_address !== 14'd3) begin
         failures++;
         $display("FAIL rmid_busy_start got addr=%0d want=3", mem_address);
      end
      tick;
      checks++;
      if (out_data !== 16'h4444 || out_last !== 1'b1) begin
         failures++;
         $display("FAIL rmid_word1 got data=%h last=%b want 4444/1", out_data, out_last);
      end
      tick;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL rmid_done got=%b want=1", done);
      end
      tick;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmid_idle got busy=%b valid=%b want 0/0", busy, out_valid);
      end
   endtask

`ifdef RAM_RD_CHECKSUM_EN
   task automatic test_checksum;
      ram[8] = 16'h8000;
      ram[9] = 16'h8001;
      ram[10] = 16'h0005;
      out_ready = 1'b1;
      base = 14'd8;
      len = 15'd3;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (checksum !== 16'h0000) begin
         failures++;
         $display("FAIL csum_clear got=%h want=0000", checksum);
      end
      repeat (6) tick;
      checks++;
      if (done !== 1'b1 || checksum !== 16'h0006) begin
         failures++;
         $display("FAIL csum_final got done=%b sum=%h want 1/0006", done, checksum);
      end
      tick;
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      done_cnt = 0;
      reset = 1'b1;
      start = 1'b0;
      base = '0;
      len = '0;
      out_ready = 1'b0;
      for (int a = 0; a < 16384; a++) ram[a] = 16'h0000;
      ram[0] = 16'h1111;
      ram[1] = 16'h2222;
      ram[2] = 16'h3333;
      ram[3] = 16'h4444;
      test_reset;
      test_stream;
      test_backpressure;
      test_wrap;
      test_len_zero;
      test_reset_mid;
`ifdef RAM_RD_CHECKSUM_EN
      test_checksum;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
